// File: rtl/udp_csum_fifo_reader.sv
// Read-side controller for the UDP checksum FIFO: takes a length/checksum descriptor,
// pops the datagram words and streams bytes with the final checksum patched in.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a descriptor; short descriptors are rejected here
// FETCH | pop the next datagram word (stalls while the FIFO is empty)
// WAIT  | FIFO read latency; capture the popped word
// SEND  | emit the 4 bytes of the captured word (or fewer on the last word)

module udp_csum_fifo_reader #(
  parameter int c_LEN_WIDTH   = 16,
  parameter int c_CSUM_OFFSET = 6
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [c_LEN_WIDTH-1:0] desc_len,
  input  logic [15:0]            desc_csum,
  output logic                   fifo_rd_en,
  input  logic [31:0]            fifo_rd_data,
  input  logic                   fifo_empty,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   tx_last,
  input  logic                   tx_ready,
  output logic                   err_len,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  localparam logic [c_LEN_WIDTH-1:0] LEN_MIN = c_LEN_WIDTH'(8);
  localparam logic [c_LEN_WIDTH-1:0] LEN_ONE = c_LEN_WIDTH'(1);
  localparam logic [c_LEN_WIDTH-1:0] CSUM_HI = c_LEN_WIDTH'(c_CSUM_OFFSET);
  localparam logic [c_LEN_WIDTH-1:0] CSUM_LO = c_LEN_WIDTH'(c_CSUM_OFFSET + 1);

  logic [1:0]             state_q, state_d;
  logic [c_LEN_WIDTH-1:0] len_q, len_d;
  logic [c_LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]            csum_q, csum_d;
  logic [31:0]            word_q, word_d;
  logic [1:0]             lane_q, lane_d;

  logic                   len_ok;
  logic                   last_byte;
  logic [7:0]             lane_byte;

  assign len_ok    = (desc_len >= LEN_MIN);
  // len_q >= 8 whenever SEND is reachable, so len_q - 1 never underflows
  assign last_byte = (byte_cnt_q == (len_q - LEN_ONE));

  always_comb begin
    lane_byte = 8'h00;
    case (lane_q)
      2'd0:    lane_byte = word_q[31:24];
      2'd1:    lane_byte = word_q[23:16];
      2'd2:    lane_byte = word_q[15:8];
      default: lane_byte = word_q[7:0];
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_q == S_SEND) begin
      if (byte_cnt_q == CSUM_HI) begin
        tx_data = csum_q[15:8];
      end else if (byte_cnt_q == CSUM_LO) begin
        tx_data = csum_q[7:0];
      end else begin
        tx_data = lane_byte;
      end
    end
  end

  assign desc_ready = (state_q == S_IDLE);
  assign err_len    = (state_q == S_IDLE) && desc_valid && !len_ok;
  assign fifo_rd_en = (state_q == S_FETCH) && !fifo_empty;
  assign tx_valid   = (state_q == S_SEND);
  assign tx_last    = (state_q == S_SEND) && last_byte;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    word_d     = word_q;
    lane_d     = lane_q;
    case (state_q)
      S_IDLE: begin
        if (desc_valid && len_ok) begin
          len_d      = desc_len;
          // zero is transmitted as all-ones (UDP "no checksum" is reserved)
          csum_d     = (desc_csum == 16'h0000) ? 16'hFFFF : desc_csum;
          byte_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        word_d  = fifo_rd_data;
        lane_d  = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          byte_cnt_d = byte_cnt_q + LEN_ONE;
          lane_d     = lane_q + 2'd1;
          if (last_byte) begin
            state_d = S_IDLE;
          end else if (lane_q == 2'd3) begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      csum_q     <= 16'h0000;
      word_q     <= 32'h0000_0000;
      lane_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
    end
  end

endmodule

// File: tb/tb_udp_csum_fifo_reader.sv
// Bench for udp_csum_fifo_reader: FIFO model, expected-byte scoreboard built from the
// datagram words, and a per-cycle output checker.

module tb_udp_csum_fifo_reader;

  localparam int OFF = 6;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_len;
  logic [15:0] desc_csum;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic        err_len;
  logic        busy;

  udp_csum_fifo_reader #(.c_LEN_WIDTH(16), .c_CSUM_OFFSET(OFF)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_len     (desc_len),
    .desc_csum    (desc_csum),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .err_len      (err_len),
    .busy         (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // FIFO model: show-ahead free, data appears one cycle after the pop
  logic [31:0] fmem [0:255];
  int wp = 0;
  int rp = 0;
  int pop_cnt = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rp           <= wp;
      fifo_rd_data <= 32'h0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rp];
      rp           <= rp + 1;
      pop_cnt      <= pop_cnt + 1;
    end
  end

  // expected stream {last, byte} and log of accepted bytes
  logic [8:0]  emem [0:1023];
  int          ewp = 0;
  int          erp = 0;
  logic [8:0]  olog [0:1023];
  int          on = 0;
  logic        stalled;
  logic [7:0]  prev_data;

  initial begin
    stalled   = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge rd_clk);
      if (!rd_rst_n) begin
        erp     = ewp;
        stalled = 1'b0;
      end else begin
        if (fifo_rd_en) chk("pop_while_empty", fifo_empty, 1'b0);
        if (stalled) begin
          chk("stall_valid", tx_valid, 1'b1);
          chk("stall_data", tx_data, prev_data);
        end
        if (tx_valid) begin
          if (erp == ewp) begin
            chk("spurious_byte", tx_valid, 1'b0);
          end else begin
            chk("tx_data", tx_data, emem[erp][7:0]);
            chk("tx_last", tx_last, emem[erp][8]);
            if (tx_ready) begin
              olog[on] = {tx_last, tx_data};
              on++;
              erp++;
            end
          end
        end
        stalled   = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  logic bp_mode = 1'b0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge rd_clk);
      #1;
      tx_ready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  logic [31:0] fw [0:15];
  logic [7:0]  exp_basic [0:11];
  logic [7:0]  exp_odd [0:8];

  task automatic push_words(input int len);
    for (int k = 0; k < (len + 3) / 4; k++) begin
      fmem[wp] = fw[k];
      wp++;
    end
  endtask

  // expected bytes come straight from the datagram: word bytes big-endian, checksum patched
  task automatic post_frame(input int len, input logic [15:0] csum, input bit push);
    logic [15:0] ce;
    logic [31:0] w;
    logic [7:0]  b;
    ce = (csum == 16'h0000) ? 16'hFFFF : csum;
    for (int i = 0; i < len; i++) begin
      w = fw[i / 4];
      b = 8'(w >> (24 - 8 * (i % 4)));
      if (i == OFF)     b = ce[15:8];
      if (i == OFF + 1) b = ce[7:0];
      emem[ewp] = {(i == len - 1), b};
      ewp++;
    end
    if (push) push_words(len);
    desc_len   = 16'(len);
    desc_csum  = csum;
    desc_valid = 1'b1;
    #1;
    chk("desc_ready_idle", desc_ready, 1'b1);
    @(posedge rd_clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_pops, input int pop0, input string nm);
    int n;
    n = 0;
    while ((erp != ewp || busy) && n < 3000) begin
      @(posedge rd_clk);
      #1;
      n++;
    end
    chk({nm, "_done"}, (erp == ewp) && !busy, 1'b1);
    chk({nm, "_pops"}, pop_cnt - pop0, exp_pops);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_desc_ready"}, desc_ready, 1'b1);
    chk({nm, "_fifo_rd_en"}, fifo_rd_en, 1'b0);
    chk({nm, "_tx_valid"}, tx_valid, 1'b0);
    chk({nm, "_tx_last"}, tx_last, 1'b0);
    chk({nm, "_tx_data"}, tx_data, 8'h00);
    chk({nm, "_err_len"}, err_len, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  task automatic load_basic();
    fw[0] = 32'h1234_0050;
    fw[1] = 32'h000C_0000;
    fw[2] = 32'hDEAD_BEEF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, o0, o1, n;
    exp_basic = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hAB, 8'hCD,
                  8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_odd   = '{8'hAA, 8'hBB, 8'h00, 8'h09, 8'h00, 8'h09, 8'hFF, 8'hFF, 8'h77};
    rd_rst_n   = 1'b0;
    desc_valid = 1'b0;
    desc_len   = 16'h0;
    desc_csum  = 16'h0;
    repeat (3) @(posedge rd_clk);
    #1;
    check_reset_outputs("reset");
    rd_rst_n = 1'b1;
    @(posedge rd_clk);
    #1;

    // basic frame with latency checks
    load_basic();
    p0 = pop_cnt;
    o0 = on;
    post_frame(12, 16'hABCD, 1'b1);
    chk("lat_e1_rd_en", fifo_rd_en, 1'b1);
    chk("lat_e1_valid", tx_valid, 1'b0);
    @(posedge rd_clk);
    #1;
    chk("lat_e2_valid", tx_valid, 1'b0);
    @(posedge rd_clk);
    #1;
    chk("lat_e3_valid", tx_valid, 1'b1);
    wait_done(3, p0, "basic");
    chk("basic_count", on - o0, 12);
    for (int i = 0; i < 12; i++) chk("basic_byte", olog[o0 + i][7:0], exp_basic[i]);
    chk("basic_last", olog[o0 + 11][8], 1'b1);

    // odd length, zero checksum
    fw[0] = 32'hAABB_0009;
    fw[1] = 32'h0009_5555;
    fw[2] = 32'h7712_3456;
    p0 = pop_cnt;
    o0 = on;
    post_frame(9, 16'h0000, 1'b1);
    wait_done(3, p0, "odd");
    chk("odd_count", on - o0, 9);
    for (int i = 0; i < 9; i++) chk("odd_byte", olog[o0 + i][7:0], exp_odd[i]);
    chk("odd_last", olog[o0 + 8][8], 1'b1);

    // backpressure
    load_basic();
    bp_mode = 1'b1;
    p0 = pop_cnt;
    o0 = on;
    post_frame(12, 16'hABCD, 1'b1);
    wait_done(3, p0, "bp");
    bp_mode = 1'b0;
    chk("bp_count", on - o0, 12);
    for (int i = 0; i < 12; i++) chk("bp_byte", olog[o0 + i][7:0], exp_basic[i]);

    // underflow: descriptor first, words 20 cycles later
    load_basic();
    p0 = pop_cnt;
    post_frame(12, 16'h0F0F, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("uf_rd_en", fifo_rd_en, 1'b0);
      chk("uf_valid", tx_valid, 1'b0);
      @(posedge rd_clk);
      #1;
    end
    push_words(12);
    wait_done(3, p0, "uf");

    // short descriptor rejected, then a valid one
    p0 = pop_cnt;
    desc_len   = 16'd5;
    desc_csum  = 16'h1111;
    desc_valid = 1'b1;
    #1;
    chk("short_err", err_len, 1'b1);
    chk("short_ready", desc_ready, 1'b1);
    @(posedge rd_clk);
    #1;
    desc_valid = 1'b0;
    #1;
    chk("short_err_pulse", err_len, 1'b0);
    chk("short_busy", busy, 1'b0);
    repeat (5) @(posedge rd_clk);
    #1;
    chk("short_pops", pop_cnt - p0, 0);
    fw[0] = 32'h0001_0002;
    fw[1] = 32'h0008_0000;
    o0 = on;
    post_frame(8, 16'h5A5A, 1'b1);
    wait_done(2, p0, "after_short");
    chk("after_short_b6", olog[o0 + 6][7:0], 8'h5A);

    // reset after the 5th byte
    load_basic();
    o0 = on;
    post_frame(12, 16'hABCD, 1'b1);
    n = 0;
    while (on < o0 + 5 && n < 500) begin
      @(posedge rd_clk);
      #1;
      n++;
    end
    chk("rst_reached5", on - o0, 5);
    rd_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    @(posedge rd_clk);
    #1;
    fw[0] = 32'hCAFE_0008;
    fw[1] = 32'h0000_0000;
    p0 = pop_cnt;
    o1 = on;
    post_frame(8, 16'h2468, 1'b1);
    wait_done(2, p0, "post_rst");
    chk("post_rst_count", on - o1, 8);
    chk("post_rst_last", olog[o1 + 7][8], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udp_csum_fifo_reader.md
# udp_csum_fifo_reader

Read-side controller for the UDP checksum FIFO in the SFP transmit path. The upstream checksum engine pushes each UDP datagram (8-byte header plus payload, big-endian 32-bit words) into the FIFO. When the checksum is known, the engine posts a length/checksum descriptor. This block takes that descriptor, pops the datagram words from the FIFO and emits a byte stream to the MAC/IP framer, with the final checksum substituted into header bytes 6–7.

## Interface
Parameters:
- c_LEN_WIDTH, 16, width of the descriptor length field and the byte counter.
- c_CSUM_OFFSET, 6, byte index of the checksum MSB within the datagram; the LSB is at offset+1.

Ports:
- rd_clk  in  1  single clock; also drives the FIFO read port.
- rd_rst_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor available.
- desc_ready  out  1  descriptor accepted when desc_valid && desc_ready.
- desc_len  in  c_LEN_WIDTH  UDP length in bytes (header + payload).
- desc_csum  in  16  computed UDP checksum.
- fifo_rd_en  out  1  FIFO pop strobe.
- fifo_rd_data  in  32  FIFO read data, valid one cycle after fifo_rd_en (no output register).
- fifo_empty  in  1  FIFO empty flag.
- tx_data  out  8  stream byte.
- tx_valid  out  1  byte valid.
- tx_last  out  1  last byte of datagram.
- tx_ready  in  1  downstream accept.
- err_len  out  1  one-cycle pulse: descriptor rejected because desc_len < 8.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, WAIT, SEND.
- **IDLE:** desc_ready=1.
  - On handshake with desc_len ≥ 8: latch len, store csum_q = (desc_csum==16'h0000) ? 16'hFFFF : desc_csum, clear byte_cnt, go FETCH.
  - On handshake with desc_len < 8: pulse err_len, no FIFO access, stay IDLE.
- **FETCH:** fifo_rd_en = !fifo_empty (combinational). If asserted, go WAIT; otherwise hold in FETCH (underflow stall, tx_valid=0).
- **WAIT:** capture fifo_rd_data into word_q, clear lane index, go SEND.
- **SEND:** tx_valid=1.
  - tx_data = word_q byte selected by lane index (0 = bits 31:24 … 3 = bits 7:0).
  - Overridden with csum_q[15:8] when byte_cnt == c_CSUM_OFFSET and csum_q[7:0] when byte_cnt == c_CSUM_OFFSET+1.
  - On tx_valid && tx_ready: byte_cnt++, lane++.
    - If byte_cnt == len-1: tx_last was 1; go IDLE. Unused trailing bytes of the last word are discarded.
    - Else if lane == 3: go FETCH.
- Exactly ceil(len/4) FIFO pops per accepted descriptor; zero pops for rejected descriptors.
- tx_data/tx_last hold stable while tx_valid && !tx_ready.
- tx_last = (state==SEND) && (byte_cnt == len-1).
- byte_cnt is c_LEN_WIDTH bits wide. len=65535 must not wrap before tx_last.

## Timing
- Reset (async assert, sync release): state=IDLE.
  - desc_ready=1.
  - fifo_rd_en=0, tx_valid=0, tx_last=0, tx_data=8'h00, err_len=0, busy=0.
  - word_q, csum_q and byte_cnt are cleared.
- Descriptor handshake at edge E0:
  - fifo_rd_en high in cycle E0+1 (FIFO non-empty).
  - Data captured at edge E0+2.
  - First tx_valid in cycle E0+3.
- Word boundary: lane-3 byte accepted at edge k → next tx_valid in cycle k+3 (2 idle cycles). Sustained rate is 4 bytes per 6 cycles with tx_ready=1.
- tx_ready low does not add FIFO pops; a pop occurs only in FETCH.
- Reset mid-datagram: immediate return to IDLE; the partial frame is dropped with no tx_last. The FIFO is reset by the same system reset, so it is not drained here.
- A descriptor arriving while busy waits; desc_ready stays 0 until IDLE.

## Test plan
- **Basic frame:** desc_len=12, desc_csum=16'hABCD; FIFO words 32'h1234_0050, 32'h000C_0000, 32'hDEAD_BEEF, tx_ready=1 → bytes 12 34 00 50 00 0C AB CD DE AD BE EF; tx_last on the 12th byte; exactly 3 pops; first tx_valid 3 cycles after handshake.
- **Odd length and zero checksum:** desc_len=9, desc_csum=0 → bytes 6–7 = FF FF; 9 bytes out; 3 pops; the last 3 bytes of word 3 are discarded.
- **Backpressure:** random tx_ready at 30% → output byte sequence identical to the basic test; tx_data stable while stalled; pop count unchanged.
- **Underflow:** FIFO empty for 20 cycles after the handshake, then filled → fifo_rd_en stays 0 and tx_valid stays 0 during the gap; frame then correct.
- **Short descriptor:** desc_len=5 → err_len one-cycle pulse; no pops; desc_ready stays 1; a following valid descriptor is processed normally.
- **Reset mid-operation:** rd_rst_n low after the 5th byte → all outputs return to reset values asynchronously; after release, a new 8-byte descriptor yields exactly 8 bytes with tx_last.
